// File: rtl/decoder_3to8.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_3to8
//  Description : Registered 3-to-8 line decoder. The select index {a,b,c}
//                (a = MSB) picks one of eight output lines. That line goes
//                active one clock after it is sampled, and the other seven go
//                inactive. All outputs come straight from flops, so they are
//                glitch-free.
//
//  Parameters  : OUT_ACTIVE_LOW - 0: active level 1; 1: every y line inverted
//                USE_ENABLE     - 1: en gates decoding; 0: en ignored (as 1)
//
//  Ports       : clk    in   rising-edge clock
//                rst    in   synchronous, active-high reset
//                a,b,c  in   select index (a = bit 2, c = bit 0)
//                en     in   decode enable, active-high
//                y0..y7 out  decoded lines, yN active when {a,b,c} == N
//                valid  out  registered outputs hold an enabled decode
//                            (never inverted)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_3to8 #(
   parameter int unsigned OUT_ACTIVE_LOW = 0,
   parameter int unsigned USE_ENABLE     = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic en,
   output logic y0,
   output logic y1,
   output logic y2,
   output logic y3,
   output logic y4,
   output logic y5,
   output logic y6,
   output logic y7,
   output logic valid
);

   // XOR mask that converts the active-high one-hot into the output level.
   // The same mask also serves as the all-inactive pattern.
   localparam logic [7:0] c_POL_MASK = (OUT_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic       c_USE_EN   = (USE_ENABLE != 0);

   logic [2:0] w_idx;
   logic       w_en;
   logic [7:0] w_onehot;

   logic [7:0] r_y;
   logic       r_valid;

   assign w_idx = {a, b, c};
   assign w_en  = c_USE_EN ? en : 1'b1;

   // Explicit case with an all-zero default. A non-2-state index then
   // drives every line inactive instead of raising more than one line,
   // which keeps the one-hot invariant intact.
   always_comb begin
      w_onehot = 8'h00;
      if (w_en) begin
         case (w_idx)
            3'd0:    w_onehot = 8'b0000_0001;
            3'd1:    w_onehot = 8'b0000_0010;
            3'd2:    w_onehot = 8'b0000_0100;
            3'd3:    w_onehot = 8'b0000_1000;
            3'd4:    w_onehot = 8'b0001_0000;
            3'd5:    w_onehot = 8'b0010_0000;
            3'd6:    w_onehot = 8'b0100_0000;
            3'd7:    w_onehot = 8'b1000_0000;
            default: w_onehot = 8'h00;
         endcase
      end
   end

   // The registers hold the final output level, so polarity is applied
   // before the flop and the pins see no logic after it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_y     <= c_POL_MASK;
         r_valid <= 1'b0;
      end else begin
         r_y     <= w_onehot ^ c_POL_MASK;
         r_valid <= w_en;
      end
   end

   assign y0    = r_y[0];
   assign y1    = r_y[1];
   assign y2    = r_y[2];
   assign y3    = r_y[3];
   assign y4    = r_y[4];
   assign y5    = r_y[5];
   assign y6    = r_y[6];
   assign y7    = r_y[7];
   assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3to8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_3to8
//  Description : Directed self-checking bench for decoder_3to8. It drives
//                three instances from the same inputs:
//                  u_dut - default build (active-high outputs, enable used)
//                  u_al  - OUT_ACTIVE_LOW = 1
//                  u_ne  - USE_ENABLE = 0
//                Each check compares {valid, y7..y0} against a
//                hand-computed value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_3to8;

   logic clk = 1'b0;
   logic rst, a, b, c, en;

   logic d_y0, d_y1, d_y2, d_y3, d_y4, d_y5, d_y6, d_y7, d_v;
   logic l_y0, l_y1, l_y2, l_y3, l_y4, l_y5, l_y6, l_y7, l_v;
   logic n_y0, n_y1, n_y2, n_y3, n_y4, n_y5, n_y6, n_y7, n_v;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   decoder_3to8 u_dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en),
      .y0(d_y0), .y1(d_y1), .y2(d_y2), .y3(d_y3),
      .y4(d_y4), .y5(d_y5), .y6(d_y6), .y7(d_y7), .valid(d_v)
   );

   decoder_3to8 #(.OUT_ACTIVE_LOW(1), .USE_ENABLE(1)) u_al (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en),
      .y0(l_y0), .y1(l_y1), .y2(l_y2), .y3(l_y3),
      .y4(l_y4), .y5(l_y5), .y6(l_y6), .y7(l_y7), .valid(l_v)
   );

   decoder_3to8 #(.OUT_ACTIVE_LOW(0), .USE_ENABLE(0)) u_ne (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en),
      .y0(n_y0), .y1(n_y1), .y2(n_y2), .y3(n_y3),
      .y4(n_y4), .y5(n_y5), .y6(n_y6), .y7(n_y7), .valid(n_v)
   );

   function automatic logic [8:0] obs_d();
      return {d_v, d_y7, d_y6, d_y5, d_y4, d_y3, d_y2, d_y1, d_y0};
   endfunction
   function automatic logic [8:0] obs_l();
      return {l_v, l_y7, l_y6, l_y5, l_y4, l_y3, l_y2, l_y1, l_y0};
   endfunction
   function automatic logic [8:0] obs_n();
      return {n_v, n_y7, n_y6, n_y5, n_y4, n_y3, n_y2, n_y1, n_y0};
   endfunction

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Inputs change at the falling edge. Outputs are sampled 1 ns after the
   // following rising edge.
   task automatic step(input logic [2:0] idx, input logic e, input logic r);
      @(negedge clk);
      {a, b, c} = idx;
      en  = e;
      rst = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [8:0] exp;
      rst = 1'b1; en = 1'b1; {a, b, c} = 3'b101;

      // Reset held for two edges with a live index and enable.
      step(3'b101, 1'b1, 1'b1);
      check("reset1", obs_d(), 9'b0_0000_0000);
      step(3'b101, 1'b1, 1'b1);
      check("reset2", obs_d(), 9'b0_0000_0000);
      check("reset_al", obs_l(), 9'b0_1111_1111);
      check("reset_ne", obs_n(), 9'b0_0000_0000);

      // First decode after reset release.
      step(3'b101, 1'b1, 1'b0);
      check("first_y5", obs_d(), 9'b1_0010_0000);

      // Full sweep: y0..y7 in order.
      for (int i = 0; i < 8; i++) begin
         step(i[2:0], 1'b1, 1'b0);
         exp = {1'b1, 8'(1 << i)};
         check($sformatf("sweep%0d", i), obs_d(), exp);
      end

      // Sweep with a single-edge reset at index 100.
      for (int i = 0; i < 8; i++) begin
         step(i[2:0], 1'b1, (i == 4));
         exp = (i == 4) ? 9'b0_0000_0000 : {1'b1, 8'(1 << i)};
         check($sformatf("midrst%0d", i), obs_d(), exp);
      end

      // Enable gating at index 011. u_ne ignores en.
      step(3'b011, 1'b1, 1'b0);
      check("en1_y3", obs_d(), 9'b1_0000_1000);
      step(3'b011, 1'b0, 1'b0);
      check("en0_off", obs_d(), 9'b0_0000_0000);
      check("en0_al_off", obs_l(), 9'b0_1111_1111);
      check("en0_ne_y3", obs_n(), 9'b1_0000_1000);
      step(3'b011, 1'b1, 1'b0);
      check("en1_y3_again", obs_d(), 9'b1_0000_1000);

      // Wrap 111 <-> 000 back to back. Exactly one of y7/y0 is high.
      for (int i = 0; i < 6; i++) begin
         step((i % 2 == 0) ? 3'b111 : 3'b000, 1'b1, 1'b0);
         exp = (i % 2 == 0) ? 9'b1_1000_0000 : 9'b1_0000_0001;
         check($sformatf("wrap%0d", i), obs_d(), exp);
         check($sformatf("wrap_xor%0d", i), {8'h00, d_y7 ^ d_y0}, 9'd1);
      end

      // Only the value present at the edge is captured.
      @(negedge clk);
      {a, b, c} = 3'b001; en = 1'b1; rst = 1'b0;
      #2 {a, b, c} = 3'b110;
      @(posedge clk);
      #1;
      check("edge_sample_y6", obs_d(), 9'b1_0100_0000);

      // Active-low build: y2 low, the other seven high, valid high.
      step(3'b010, 1'b1, 1'b0);
      check("al_y2", obs_l(), 9'b1_1111_1011);
      check("ah_y2", obs_d(), 9'b1_0000_0100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
